// File: rtl/pixel_stream_collector_if.sv
// Pixel stream bundle between the collector and its neighbours: the
// non-back-pressurable upstream pixel feed, the downstream valid/ready
// stream with line/frame tags, and the collector's status outputs.
interface pixel_stream_collector_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_pixel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pixel;
    logic              out_eol;
    logic              out_eof;
    logic              almost_full;
    logic              overflow;
    logic              frame_done;

    // Environment side: feeds pixels and accepts the output stream.
    modport master (
        output in_valid, in_pixel, out_ready,
        input  out_valid, out_pixel, out_eol, out_eof,
        input  almost_full, overflow, frame_done
    );

    // Collector side.
    modport slave (
        input  in_valid, in_pixel, out_ready,
        output out_valid, out_pixel, out_eol, out_eof,
        output almost_full, overflow, frame_done
    );
endinterface

// File: rtl/pixel_stream_collector.sv
// Collects the fixed-latency pixel stream into a small circular FIFO and
// re-emits it with a valid/ready handshake, tagging end-of-line and
// end-of-frame from position counters that advance only on accepted pixels.
// Dropped pixels (FIFO full, no pop) set a sticky overflow flag; frame
// alignment is then lost until the next reset.
module pixel_stream_collector #(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pixel_stream_collector_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              overflow_flag;
    logic              frame_done_flag;

    logic not_empty;
    logic pop;
    logic push;
    logic drop;
    logic eol;
    logic eof;

    // Handshake decode; a pop frees a slot so a full FIFO can still take a pixel.
    always_comb begin
        not_empty = (count != '0);
        pop       = not_empty && bus.out_ready;
        push      = bus.in_valid && ((count != CNT_FULL) || pop);
        drop      = bus.in_valid && (count == CNT_FULL) && !pop;
        eol       = not_empty && (col == COL_LAST);
        eof       = eol && (row == ROW_LAST);
    end

    // Pixel storage; contents are not reset, writes are suppressed during reset.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= bus.in_pixel;
        end
    end

    // Pointers, occupancy, frame position and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            col             <= '0;
            row             <= '0;
            overflow_flag   <= 1'b0;
            frame_done_flag <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow_flag <= 1'b1;
            end
            frame_done_flag <= pop && eof;
        end
    end

    assign bus.out_valid   = not_empty;
    assign bus.out_pixel   = mem[rd_ptr];
    assign bus.out_eol     = eol;
    assign bus.out_eof     = eof;
    assign bus.almost_full = (count >= CNT_AF);
    assign bus.overflow    = overflow_flag;
    assign bus.frame_done  = frame_done_flag;
endmodule
